// File: rtl/systolic_feed_sched.sv
// -----------------------------------------------------------------------------
// systolic_feed_sched
//   Read-side scheduler for the row FIFOs that feed the left edge of a
//   systolic array. For each tile it drains tile_len words from every row
//   FIFO. Row r runs r cycles behind row 0, which gives a diagonal wavefront.
//   A read request is never issued to an empty FIFO. If any row that is due
//   is empty, the whole wavefront freezes for that cycle (global stall).
//
// Handshake:
//   Each row is a read-request interface. When o_fifo_rdreq[r]=1, one word is
//   consumed from row r, and that FIFO's q is valid in the same cycle.
//   o_fifo_rdreq[r] is asserted only while i_fifo_empty[r]=0.
//   i_start is a request that is accepted only in IDLE; it is ignored at all
//   other times.
//
// Ports:
//   i_clk          clock; all state updates on posedge
//   i_rst          synchronous reset, active-high
//   i_start        begin a tile (accepted only in IDLE)
//   i_tile_len     words per row for the tile, sampled when start is accepted
//   i_fifo_empty   per-row FIFO empty flags
//   o_fifo_rdreq   per-row read request (combinational)
//   o_busy         state != IDLE
//   o_stall        RUN and a due row is empty this cycle
//   o_done         one-cycle pulse at end of tile
//   o_stall_cnt    saturating count of stall cycles in the current/last tile
//   o_state        FSM state (0=IDLE, 1=RUN, 2=DONE), exported for debug
// -----------------------------------------------------------------------------
module systolic_feed_sched #(
  parameter int NUM_ROWS  = 4,
  parameter int LEN_WIDTH = 8,
  parameter int STALL_W   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [LEN_WIDTH-1:0] i_tile_len,
  input  logic [NUM_ROWS-1:0]  i_fifo_empty,
  output logic [NUM_ROWS-1:0]  o_fifo_rdreq,
  output logic                 o_busy,
  output logic                 o_stall,
  output logic                 o_done,
  output logic [STALL_W-1:0]   o_stall_cnt,
  output logic [1:0]           o_state
);

  // Row-window compare width. It is wide enough that step, len and row
  // indices can be added without wrapping.
  localparam int CW = LEN_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LEN_WIDTH:0]   r_step;
  logic [LEN_WIDTH-1:0] r_len;
  logic [STALL_W-1:0]   r_stall_cnt;

  logic [CW-1:0]        w_step_x;
  logic [CW-1:0]        w_len_x;
  logic [CW-1:0]        w_last_step;
  logic [NUM_ROWS-1:0]  w_due;
  logic                 w_blocked;
  logic                 w_run_stall;

  assign w_step_x    = CW'(r_step);
  assign w_len_x     = CW'(r_len);
  // Last step index is S-1 = len + NUM_ROWS - 2. len >= 1 whenever in RUN,
  // so this value cannot underflow while it is in use.
  assign w_last_step = w_len_x + CW'(NUM_ROWS) - CW'(2);

  // Row r is due while step lies inside its window [r, r+len).
  always_comb begin
    w_due = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      w_due[r] = (w_step_x >= CW'(r)) && (w_step_x < (CW'(r) + w_len_x));
    end
  end

  assign w_blocked   = |(w_due & i_fifo_empty);
  assign w_run_stall = (r_state == ST_RUN) && w_blocked;

  // Next-state and output decode.
  always_comb begin
    w_state_nxt  = r_state;
    o_fifo_rdreq = '0;
    o_stall      = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_tile_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (w_blocked) begin
          o_stall = 1'b1;
        end else begin
          o_fifo_rdreq = w_due;
          if (w_step_x == w_last_step) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_step      <= '0;
      r_len       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && i_start) begin
        r_len       <= i_tile_len;
        r_step      <= '0;
        r_stall_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        if (w_run_stall) begin
          if (r_stall_cnt != {STALL_W{1'b1}}) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
          end
        end else begin
          r_step <= r_step + (LEN_WIDTH + 1)'(1);
        end
      end
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_stall_cnt = r_stall_cnt;
  assign o_state     = r_state;

endmodule

// File: tb/tb_systolic_feed_sched.sv
// -----------------------------------------------------------------------------
// tb_systolic_feed_sched
//   Bench for systolic_feed_sched with NUM_ROWS=4, LEN_WIDTH=8, STALL_W=16.
//   Inputs are driven on the falling edge. Outputs are sampled 2 time units
//   later, well before the next rising edge. Fixed scenarios compare against
//   expected per-cycle values held in queues. The randomized scenario compares
//   against a wavefront model: row r reads word j at wavefront position r+j,
//   and the position advances on every cycle that is not blocked.
// -----------------------------------------------------------------------------
module tb_systolic_feed_sched;

  localparam int N  = 4;
  localparam int LW = 8;
  localparam int SW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [LW-1:0] tile_len;
  logic [N-1:0]  fifo_empty;
  logic [N-1:0]  rdreq;
  logic          busy;
  logic          stall;
  logic          done;
  logic [SW-1:0] stall_cnt;
  logic [1:0]    state;

  int tests_run;
  int fail_cnt;

  logic [N-1:0] exp_q[$];
  logic [2:0]   ctl_q[$];   // {stall, done, busy}

  systolic_feed_sched #(.NUM_ROWS(N), .LEN_WIDTH(LW), .STALL_W(SW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_tile_len(tile_len),
    .i_fifo_empty(fifo_empty), .o_fifo_rdreq(rdreq), .o_busy(busy),
    .o_stall(stall), .o_done(done), .o_stall_cnt(stall_cnt), .o_state(state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1; start = 1'b0; tile_len = '0; fifo_empty = '0;
  end

  // ---------------- driver ----------------
  task automatic drive(input logic rst_v, input logic start_v,
                       input logic [LW-1:0] len_v, input logic [N-1:0] empty_v);
    @(negedge clk);
    rst = rst_v; start = start_v; tile_len = len_v; fifo_empty = empty_v;
    #2;
  endtask

  // Compare one cycle of rdreq and {stall,done,busy} against the queue heads.
  // Everything is written inline in each scenario to keep the scenarios independent.

  // ---------------- scenarios ----------------
  task automatic test_reset;
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b0, 1'b0, '0, '0);
    tests_run++;
    if ({rdreq, busy, stall, done} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_outputs: got rdreq=%b busy=%b stall=%b done=%b, want all 0", rdreq, busy, stall, done);
    end
    tests_run++;
    if (stall_cnt !== '0 || state !== 2'd0) begin
      fail_cnt++;
      $display("FAIL reset_state: got stall_cnt=%0d state=%0d, want 0/0", stall_cnt, state);
    end
  endtask

  task automatic test_basic;
    logic [N-1:0] e;
    logic [2:0]   k;
    exp_q = '{4'h0, 4'h1, 4'h3, 4'h7, 4'he, 4'hc, 4'h8, 4'h0, 4'h0};
    ctl_q = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b011, 3'b000};
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, c == 0, 8'd3, '0);
      e = exp_q.pop_front();
      k = ctl_q.pop_front();
      tests_run++;
      if (rdreq !== e || {stall, done, busy} !== k) begin
        fail_cnt++;
        $display("FAIL basic_c%0d: got rdreq=%b sdb=%b, want rdreq=%b sdb=%b", c, rdreq, {stall, done, busy}, e, k);
      end
    end
    tests_run++;
    if (stall_cnt !== 16'd0) begin
      fail_cnt++;
      $display("FAIL basic_stall_cnt: got %0d, want 0", stall_cnt);
    end
  endtask

  task automatic test_stall;
    logic [N-1:0] e;
    logic [2:0]   k;
    exp_q = '{4'h0, 4'h1, 4'h3, 4'h0, 4'h0, 4'h7, 4'he, 4'hc, 4'h8, 4'h0, 4'h0};
    ctl_q = '{3'b000, 3'b001, 3'b001, 3'b101, 3'b101, 3'b001, 3'b001, 3'b001, 3'b001, 3'b011, 3'b000};
    for (int c = 0; c < 11; c++) begin
      drive(1'b0, c == 0, 8'd3, (c == 3 || c == 4) ? 4'b0100 : 4'b0000);
      e = exp_q.pop_front();
      k = ctl_q.pop_front();
      tests_run++;
      if (rdreq !== e || {stall, done, busy} !== k) begin
        fail_cnt++;
        $display("FAIL stall_c%0d: got rdreq=%b sdb=%b, want rdreq=%b sdb=%b", c, rdreq, {stall, done, busy}, e, k);
      end
    end
    tests_run++;
    if (stall_cnt !== 16'd2) begin
      fail_cnt++;
      $display("FAIL stall_cnt: got %0d, want 2", stall_cnt);
    end
  endtask

  task automatic test_not_due_empty;
    logic [N-1:0] e;
    logic [2:0]   k;
    exp_q = '{4'h0, 4'h1, 4'h3, 4'h7, 4'he, 4'hc, 4'h8, 4'h0, 4'h0};
    ctl_q = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b011, 3'b000};
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, c == 0, 8'd3, (c >= 1 && c <= 3) ? 4'b1000 : 4'b0000);
      e = exp_q.pop_front();
      k = ctl_q.pop_front();
      tests_run++;
      if (rdreq !== e || {stall, done, busy} !== k) begin
        fail_cnt++;
        $display("FAIL not_due_c%0d: got rdreq=%b sdb=%b, want rdreq=%b sdb=%b", c, rdreq, {stall, done, busy}, e, k);
      end
    end
  endtask

  task automatic test_zero_len_and_ignored_start;
    logic [N-1:0] e;
    logic [2:0]   k;
    exp_q = '{4'h0, 4'h0, 4'h0};
    ctl_q = '{3'b000, 3'b011, 3'b000};
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, c == 0, 8'd0, '0);
      e = exp_q.pop_front();
      k = ctl_q.pop_front();
      tests_run++;
      if (rdreq !== e || {stall, done, busy} !== k) begin
        fail_cnt++;
        $display("FAIL zero_len_c%0d: got rdreq=%b sdb=%b, want rdreq=%b sdb=%b", c, rdreq, {stall, done, busy}, e, k);
      end
    end
    // K=3 tile with a second start (different length) pulsed mid-tile.
    exp_q = '{4'h0, 4'h1, 4'h3, 4'h7, 4'he, 4'hc, 4'h8, 4'h0, 4'h0, 4'h0};
    ctl_q = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b011, 3'b000, 3'b000};
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, (c == 0) || (c == 3), (c == 3) ? 8'd7 : 8'd3, '0);
      e = exp_q.pop_front();
      k = ctl_q.pop_front();
      tests_run++;
      if (rdreq !== e || {stall, done, busy} !== k) begin
        fail_cnt++;
        $display("FAIL ignored_start_c%0d: got rdreq=%b sdb=%b, want rdreq=%b sdb=%b", c, rdreq, {stall, done, busy}, e, k);
      end
    end
  endtask

  task automatic test_reset_mid_tile;
    logic [N-1:0] e;
    logic [2:0]   k;
    // Stall once at cycle 2 so the counter is non-zero before the reset.
    exp_q = '{4'h0, 4'h1, 4'h0, 4'h3, 4'h7, 4'h0, 4'h0};
    ctl_q = '{3'b000, 3'b001, 3'b101, 3'b001, 3'b001, 3'b000, 3'b000};
    for (int c = 0; c < 7; c++) begin
      drive(c == 4, c == 0, 8'd3, (c == 2) ? 4'b0010 : 4'b0000);
      e = exp_q.pop_front();
      k = ctl_q.pop_front();
      tests_run++;
      if (rdreq !== e || {stall, done, busy} !== k) begin
        fail_cnt++;
        $display("FAIL rst_mid_c%0d: got rdreq=%b sdb=%b, want rdreq=%b sdb=%b", c, rdreq, {stall, done, busy}, e, k);
      end
      if (c == 5) begin
        tests_run++;
        if (state !== 2'd0 || stall_cnt !== 16'd0) begin
          fail_cnt++;
          $display("FAIL rst_mid_state: got state=%0d stall_cnt=%0d, want 0/0", state, stall_cnt);
        end
      end
    end
    // A new K=2 tile after the reset runs normally (S=5, done at cycle 6).
    exp_q = '{4'h0, 4'h1, 4'h3, 4'h6, 4'hc, 4'h8, 4'h0, 4'h0};
    ctl_q = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b011, 3'b000};
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, c == 0, 8'd2, '0);
      e = exp_q.pop_front();
      k = ctl_q.pop_front();
      tests_run++;
      if (rdreq !== e || {stall, done, busy} !== k) begin
        fail_cnt++;
        $display("FAIL rst_new_c%0d: got rdreq=%b sdb=%b, want rdreq=%b sdb=%b", c, rdreq, {stall, done, busy}, e, k);
      end
    end
  endtask

  task automatic test_saturation;
    int bad;
    int run_cycles;
    int reads[N];
    bit seen_done;
    bad = 0; run_cycles = 0; seen_done = 0;
    for (int r = 0; r < N; r++) reads[r] = 0;
    drive(1'b0, 1'b1, 8'd255, '0);
    for (int c = 0; c < 70000; c++) begin
      drive(1'b0, 1'b0, '0, 4'b0001);
      if (stall !== 1'b1 || rdreq !== '0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      fail_cnt++;
      $display("FAIL sat_hold: got %0d non-stalled cycles, want 0", bad);
    end
    tests_run++;
    if (stall_cnt !== 16'hFFFF) begin
      fail_cnt++;
      $display("FAIL sat_cnt: got %h, want ffff", stall_cnt);
    end
    for (int c = 0; c < 300 && !seen_done; c++) begin
      drive(1'b0, 1'b0, '0, '0);
      if (done === 1'b1) seen_done = 1;
      else begin
        run_cycles++;
        for (int r = 0; r < N; r++) if (rdreq[r] === 1'b1) reads[r]++;
      end
    end
    tests_run++;
    if (!seen_done || run_cycles != 258) begin
      fail_cnt++;
      $display("FAIL sat_steps: got done=%0d run_cycles=%0d, want 1/258", seen_done, run_cycles);
    end
    for (int r = 0; r < N; r++) begin
      tests_run++;
      if (reads[r] != 255) begin
        fail_cnt++;
        $display("FAIL sat_reads_row%0d: got %0d, want 255", r, reads[r]);
      end
    end
    tests_run++;
    if (stall_cnt !== 16'hFFFF) begin
      fail_cnt++;
      $display("FAIL sat_cnt_after_done: got %h, want ffff", stall_cnt);
    end
    drive(1'b0, 1'b0, '0, '0);
  endtask

  // Randomized tiles checked against a wavefront model.
  task automatic test_random;
    int len, pos, total, stalls, guard;
    int reads[N];
    logic [N-1:0] due, emp, exp_rd;
    bit blocked;
    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(0, 12);
      total = (len == 0) ? 0 : len + N - 1;
      pos = 0; stalls = 0; guard = 0;
      for (int r = 0; r < N; r++) reads[r] = 0;
      drive(1'b0, 1'b1, LW'(len), LW'($urandom_range(0, 15)));
      while (pos < total && guard < 400) begin
        guard++;
        emp = '0;
        for (int r = 0; r < N; r++) emp[r] = ($urandom_range(0, 99) < 25);
        drive(1'b0, ($urandom_range(0, 9) == 0), LW'($urandom_range(0, 20)), emp);
        due = '0;
        for (int r = 0; r < N; r++) due[r] = (pos >= r) && (pos < r + len);
        blocked = |(due & emp);
        exp_rd = blocked ? '0 : due;
        tests_run++;
        if (rdreq !== exp_rd || stall !== blocked || busy !== 1'b1 || done !== 1'b0
            || (rdreq & emp) !== '0) begin
          fail_cnt++;
          $display("FAIL rand_t%0d_pos%0d: got rdreq=%b stall=%b busy=%b done=%b, want rdreq=%b stall=%b busy=1 done=0",
                   t, pos, rdreq, stall, busy, done, exp_rd, blocked);
        end
        if (blocked) stalls++;
        else begin
          for (int r = 0; r < N; r++) if (due[r]) reads[r]++;
          pos++;
        end
      end
      drive(1'b0, 1'b0, '0, LW'($urandom_range(0, 15)));
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b1 || rdreq !== '0 || stall_cnt !== SW'(stalls)) begin
        fail_cnt++;
        $display("FAIL rand_done_t%0d: got done=%b busy=%b rdreq=%b stall_cnt=%0d, want 1/1/0000/%0d",
                 t, done, busy, rdreq, stall_cnt, stalls);
      end
      for (int r = 0; r < N; r++) begin
        tests_run++;
        if (reads[r] != len) begin
          fail_cnt++;
          $display("FAIL rand_reads_t%0d_row%0d: model counted %0d, want %0d", t, r, reads[r], len);
        end
      end
      drive(1'b0, 1'b0, '0, '0);
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || stall_cnt !== SW'(stalls)) begin
        fail_cnt++;
        $display("FAIL rand_idle_t%0d: got busy=%b done=%b stall_cnt=%0d, want 0/0/%0d", t, busy, done, stall_cnt, stalls);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests_run = 0;
    fail_cnt  = 0;
    test_reset();
    test_basic();
    test_stall();
    test_not_due_empty();
    test_zero_len_and_ignored_start();
    test_reset_mid_tile();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
